path_tracer: RTL and testbench
==============================

Name: path_tracer

Overview:
- Downstream of the Dijkstra top-level.
- Once the search finishes and the Writer has stored the predecessor array in memory, this block walks that array from destination back to source and streams the path node indices to the host-side consumer.
- Issues single-word reads on the shared memory port while the Dijkstra engine is idle, then outputs path nodes under valid/ready backpressure.

Parameters:
- MAX_NODES, `DEFAULT_MAX_NODES, maximum graph size and path buffer depth.
- INDEX_WIDTH, `DEFAULT_INDEX_WIDTH, node index width.
- MADDR_WIDTH, `DEFAULT_MADDR_WIDTH, memory address width.
- MDATA_WIDTH, `DEFAULT_MDATA_WIDTH, memory data width; one predecessor entry per word.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; sampled only in IDLE/DONE
- source  in  INDEX_WIDTH  path start node
- destination  in  INDEX_WIDTH  path end node
- number_of_nodes  in  INDEX_WIDTH  graph size N
- prev_base_address  in  MADDR_WIDTH  byte address of prev[0]
- mem_read_enable  out  1  read request
- mem_addr  out  MADDR_WIDTH  read address
- mem_read_data  in  MDATA_WIDTH  read data
- mem_read_ready  in  1  read data valid
- wait_request  in  1  memory stall; request held while high
- path_valid  out  1  path_node valid
- path_node  out  INDEX_WIDTH  node index
- path_last  out  1  final beat of path
- path_ready  in  1  consumer accepts beat
- busy  out  1  trace in progress
- done  out  1  level; set on completion, cleared by next start
- error  out  1  level; unreachable node, bad index or loop; cleared by next start

Behaviour:
- Reset values:
  - Outputs: all outputs 0, mem_addr 0, path_node 0.
  - State: IDLE, with hop counter and stack pointer at 0.
  - Reset mid-trace aborts immediately. No further memory requests are issued. Any pending read data is ignored.
- Address and data:
  - Entry address = prev_base_address + idx*(MDATA_WIDTH/8), computed in MADDR_WIDTH and wrapping.
  - The entry value is mem_read_data[INDEX_WIDTH-1:0].
  - `NO_PREVIOUS_NODE marks a node with no predecessor.
- States:
  - IDLE/DONE: on start, latch the inputs, set cur = destination, clear done/error/hops, assert busy, go to CHECK.
  - CHECK:
    - If cur >= N or hops > N, set error and go to FINISH.
    - Otherwise record cur (push or emit, see feature).
    - If cur == source, go to FINISH (or DRAIN in forward mode).
    - Otherwise go to FETCH.
  - FETCH: drive mem_read_enable = 1 and mem_addr. Hold both stable until a cycle with wait_request = 0, then deassert in the next cycle and go to WAIT.
  - WAIT:
    - On mem_read_ready, capture the entry.
    - If the entry is `NO_PREVIOUS_NODE, set error and go to FINISH.
    - Otherwise set cur = entry, increment hops, and go to CHECK.
  - FINISH: busy = 0, done = 1, go to DONE.
- Stream handshake:
  - A beat transfers on path_valid && path_ready.
  - path_node and path_last are held stable while path_valid && !path_ready.
  - The FSM stalls in CHECK until the beat it is emitting is accepted.
- source == destination: exactly one beat, {destination, last = 1}, with no memory reads.
- start while busy is ignored. Inputs are sampled only on an accepted start.
- Minimum per hop: CHECK 1 cycle + FETCH 1 cycle + memory latency.

Optional Feature:
- Macro: PATH_TRACER_FORWARD_EN.
- Defined:
  - CHECK pushes cur onto an internal MAX_NODES-deep stack; nothing is streamed during the walk.
  - On reaching source, DRAIN pops and streams nodes in source->destination order. path_last is set on the destination beat.
  - On error the stack is discarded and zero beats are emitted.
  - A push with the stack full sets error.
- Undefined:
  - No stack. Nodes stream in destination->source order as visited.
  - path_last is set on the source beat.
  - On error, beats already emitted stand and no path_last is sent. The consumer must check error once done is set.

Decomposition:
- Shared package path_tracer_pkg holds:
  - the state enum {IDLE, CHECK, FETCH, WAIT, DRAIN, FINISH, DONE};
  - NO_PREVIOUS_NODE reuse;
  - the entry-address function.
- Sub-module path_stack (synchronous LIFO: push, pop, full, empty, count), instantiated only under PATH_TRACER_FORWARD_EN.

Test Plan:
1. N=5, src=0, dst=3, prev={NP,0,1,2,NP}, always ready -> stream 3,2,1,0 (forward mode 0,1,2,3) with last on the final beat; 3 reads at base+12, base+8, base+4; done=1, error=0.
2. src=dst=2 -> single beat {2, last=1}, no mem_read_enable pulse, done within 3 cycles.
3. dst=4 with prev[4]=NP, src=0 -> error=1, done=1; forward mode emits 0 beats, reverse mode emits only {4, last=0}.
4. Loop prev[1]=2, prev[2]=1, src=0, dst=1, N=3 -> error=1 after hops>3, FSM returns to DONE, no hang.
5. wait_request high 4 cycles and path_ready toggled every other cycle -> mem_addr/mem_read_enable stable across the stall, beats neither duplicated nor dropped, same output as scenario 1.
6. Reset asserted during WAIT, then a late mem_read_ready -> all outputs 0, data ignored; a fresh start traces correctly.

Source files
------------

// File: rtl/path_tracer_pkg.sv
// Shared types and helpers for the predecessor-array path tracer.
// Size defaults and the no-predecessor marker can be overridden by defining the macros before this file.
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 16
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 8
`endif
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 16
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif
`ifndef NO_PREVIOUS_NODE
`define NO_PREVIOUS_NODE 8'hFF
`endif

package path_tracer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    FETCH,
    WAIT,
    DRAIN,
    FINISH,
    DONE
  } state_e;

  localparam int unsigned NoPreviousNode = `NO_PREVIOUS_NODE;

  // Computed in 32 bits; callers truncate to their address width, which gives the wrap.
  function automatic logic [31:0] entryAddr(input logic [31:0] base, input logic [31:0] idx,
                                            input int unsigned bytesPerWord);
    return base + idx * bytesPerWord;
  endfunction

endpackage

// File: rtl/path_stack.sv
// Synchronous LIFO holding visited nodes so the path can be replayed source-first.
module path_stack #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             data_i,
  output logic [WIDTH-1:0]             top_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CntW-1:0]  count_q, count_d;
  logic [CntW-1:0]  topIdx;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign topIdx  = count_q - 1'b1;
  assign top_o   = mem_q[PtrW'(topIdx)];

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (push_i && !full_o) begin
      count_d = count_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_i && !full_o && !clear_i) begin
      mem_q[PtrW'(count_q)] <= data_i;
    end
  end

endmodule

// File: rtl/path_tracer.sv
// Walks the stored predecessor array from destination back to source and streams node indices.
// Define PATH_TRACER_FORWARD_EN to buffer the walk and stream it in source->destination order.
module path_tracer
  import path_tracer_pkg::*;
#(
  parameter int unsigned MAX_NODES   = `DEFAULT_MAX_NODES,
  parameter int unsigned INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
  parameter int unsigned MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
  parameter int unsigned MDATA_WIDTH = `DEFAULT_MDATA_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INDEX_WIDTH-1:0] source,
  input  logic [INDEX_WIDTH-1:0] destination,
  input  logic [INDEX_WIDTH-1:0] number_of_nodes,
  input  logic [MADDR_WIDTH-1:0] prev_base_address,
  output logic                   mem_read_enable,
  output logic [MADDR_WIDTH-1:0] mem_addr,
  input  logic [MDATA_WIDTH-1:0] mem_read_data,
  input  logic                   mem_read_ready,
  input  logic                   wait_request,
  output logic                   path_valid,
  output logic [INDEX_WIDTH-1:0] path_node,
  output logic                   path_last,
  input  logic                   path_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);
  localparam int unsigned BytesPerWord = MDATA_WIDTH / 8;
  localparam logic [INDEX_WIDTH-1:0] NoPrev = INDEX_WIDTH'(NoPreviousNode);

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] cur_q, cur_d, src_q, src_d, numNodes_q, numNodes_d;
  logic [MADDR_WIDTH-1:0] base_q, base_d;
  logic [INDEX_WIDTH:0]   hops_q, hops_d;
  logic                   done_q, done_d, error_q, error_d;
  logic [INDEX_WIDTH-1:0] entry;
  logic [MADDR_WIDTH-1:0] fetchAddr;
  logic                   badNode, atSource;
  logic                   unusedData;

  assign entry      = mem_read_data[INDEX_WIDTH-1:0];
  assign unusedData = ^mem_read_data[MDATA_WIDTH-1:INDEX_WIDTH];
  assign fetchAddr  = MADDR_WIDTH'(entryAddr(32'(base_q), 32'(cur_q), BytesPerWord));
  // hops beyond N can only happen if the predecessor chain loops
  assign badNode    = (cur_q >= numNodes_q) || (hops_q > {1'b0, numNodes_q});
  assign atSource   = (cur_q == src_q);
  assign done       = done_q;
  assign error      = error_q;

`ifdef PATH_TRACER_FORWARD_EN
  localparam int unsigned CntW = $clog2(MAX_NODES + 1);
  logic                   stackPush, stackPop, stackClear, stackFull, stackEmpty;
  logic [INDEX_WIDTH-1:0] stackTop;
  logic [CntW-1:0]        stackCount;

  path_stack #(.DEPTH(MAX_NODES), .WIDTH(INDEX_WIDTH)) uStack (
    .clock   (clock),
    .reset   (reset),
    .clear_i (stackClear),
    .push_i  (stackPush),
    .pop_i   (stackPop),
    .data_i  (cur_q),
    .top_o   (stackTop),
    .full_o  (stackFull),
    .empty_o (stackEmpty),
    .count_o (stackCount)
  );
`else
  logic unusedCfg;
  assign unusedCfg = (MAX_NODES == 0);
`endif

  always_comb begin
    state_d         = state_q;
    cur_d           = cur_q;
    src_d           = src_q;
    numNodes_d      = numNodes_q;
    base_d          = base_q;
    hops_d          = hops_q;
    done_d          = done_q;
    error_d         = error_q;
    mem_read_enable = 1'b0;
    mem_addr        = '0;
    path_valid      = 1'b0;
    path_node       = '0;
    path_last       = 1'b0;
    busy            = 1'b0;
`ifdef PATH_TRACER_FORWARD_EN
    stackPush       = 1'b0;
    stackPop        = 1'b0;
    stackClear      = 1'b0;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          cur_d      = destination;
          src_d      = source;
          numNodes_d = number_of_nodes;
          base_d     = prev_base_address;
          hops_d     = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
`ifdef PATH_TRACER_FORWARD_EN
          stackClear = 1'b1;
`endif
          state_d    = CHECK;
        end
      end
      CHECK: begin
        busy = 1'b1;
        if (badNode) begin
          error_d = 1'b1;
          state_d = FINISH;
`ifdef PATH_TRACER_FORWARD_EN
          stackClear = 1'b1;
        end else if (stackFull) begin
          error_d    = 1'b1;
          stackClear = 1'b1;
          state_d    = FINISH;
        end else begin
          stackPush = 1'b1;
          state_d   = atSource ? DRAIN : FETCH;
        end
`else
        end else begin
          path_valid = 1'b1;
          path_node  = cur_q;
          path_last  = atSource;
          if (path_ready) begin
            state_d = atSource ? FINISH : FETCH;
          end
        end
`endif
      end
      FETCH: begin
        busy            = 1'b1;
        mem_read_enable = 1'b1;
        mem_addr        = fetchAddr;
        if (!wait_request) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (mem_read_ready) begin
          if (entry == NoPrev) begin
            error_d = 1'b1;
            state_d = FINISH;
`ifdef PATH_TRACER_FORWARD_EN
            stackClear = 1'b1;
`endif
          end else begin
            cur_d   = entry;
            hops_d  = hops_q + 1'b1;
            state_d = CHECK;
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
`ifdef PATH_TRACER_FORWARD_EN
        path_valid = !stackEmpty;
        path_node  = stackEmpty ? '0 : stackTop;
        path_last  = (stackCount == CntW'(1));
        if (stackEmpty) begin
          state_d = FINISH;
        end else if (path_ready) begin
          stackPop = 1'b1;
          if (stackCount == CntW'(1)) begin
            state_d = FINISH;
          end
        end
`else
        state_d = FINISH;
`endif
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      src_q      <= '0;
      numNodes_q <= '0;
      base_q     <= '0;
      hops_q     <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      src_q      <= src_d;
      numNodes_q <= numNodes_d;
      base_q     <= base_d;
      hops_q     <= hops_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

endmodule

// File: tb/tb_path_tracer.sv
// Self-checking bench for path_tracer: table vectors, random traces against a walk model,
// plus hand-written reset-abort and stall/backpressure sequences.
module tb_path_tracer;
  localparam int MAXN = 16;
  localparam int IW   = 8;
  localparam int MAW  = 16;
  localparam int MDW  = 32;
  localparam logic [IW-1:0] NP = 8'hFF;
`ifdef PATH_TRACER_FORWARD_EN
  localparam int LongErr   = 1;
  localparam int LongReads = 16;
`else
  localparam int LongErr   = 0;
  localparam int LongReads = 17;
`endif

  typedef struct {
    logic [IW-1:0] node;
    logic          last;
  } beat_t;

  typedef struct {
    int            src;
    int            dst;
    int            n;
    logic [MAW-1:0] base;
    int            pattern;
    int            stall;
    int            rdy;
    bit            spur;
    int            expErr;
    int            expReads;
  } vec_t;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [IW-1:0]  source = '0, destination = '0, number_of_nodes = '0;
  logic [MAW-1:0] prev_base_address = '0;
  logic           mem_read_enable;
  logic [MAW-1:0] mem_addr;
  logic [MDW-1:0] mem_read_data;
  logic           mem_read_ready;
  logic           wait_request;
  logic           path_valid;
  logic [IW-1:0]  path_node;
  logic           path_last;
  logic           path_ready;
  logic           busy, done, error;

  path_tracer #(.MAX_NODES(MAXN), .INDEX_WIDTH(IW), .MADDR_WIDTH(MAW), .MDATA_WIDTH(MDW)) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .source            (source),
    .destination       (destination),
    .number_of_nodes   (number_of_nodes),
    .prev_base_address (prev_base_address),
    .mem_read_enable   (mem_read_enable),
    .mem_addr          (mem_addr),
    .mem_read_data     (mem_read_data),
    .mem_read_ready    (mem_read_ready),
    .wait_request      (wait_request),
    .path_valid        (path_valid),
    .path_node         (path_node),
    .path_last         (path_last),
    .path_ready        (path_ready),
    .busy              (busy),
    .done              (done),
    .error             (error)
  );

  always #5 clock = ~clock;

  logic [IW-1:0]  prevMem [64];
  logic [MAW-1:0] curBase;
  logic [MAW-1:0] pendAddr;
  int memLat, stallMode, readyMode, respCount, stallCnt;
  int checks, errors, enableCycles;
  beat_t gotBeats[$], expBeats[$];
  logic [MAW-1:0] gotReads[$], expReads[$];
  bit expErr;
  logic holdBeat, holdReq;
  beat_t heldBeat;
  logic [MAW-1:0] heldAddr;

  task automatic checkOutput(input string what, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", what, got, exp);
    end
  endtask

  // Memory responder and consumer: drive just after each rising edge.
  initial begin
    logic [MAW-1:0] off;
    path_ready = 1'b1; wait_request = 1'b0; mem_read_ready = 1'b0; mem_read_data = '0;
    respCount = 0; stallCnt = 0;
    forever begin
      @(posedge clock); #1;
      mem_read_ready = 1'b0;
      if (respCount > 0) begin
        respCount--;
        if (respCount == 0) begin
          off = pendAddr - curBase;
          mem_read_data = $urandom();
          mem_read_data[IW-1:0] = prevMem[off[7:2]];
          mem_read_ready = 1'b1;
        end
      end
      case (stallMode)
        1: begin
          if (mem_read_enable === 1'b1 && stallCnt < 4) begin
            wait_request = 1'b1; stallCnt++;
          end else begin
            wait_request = 1'b0;
            if (mem_read_enable !== 1'b1) stallCnt = 0;
          end
        end
        2: wait_request = 1'($urandom_range(0, 1));
        default: wait_request = 1'b0;
      endcase
      case (readyMode)
        1: path_ready = ~path_ready;
        2: path_ready = 1'($urandom_range(0, 1));
        default: path_ready = 1'b1;
      endcase
    end
  end

  // Observe transfers and check that held beats/requests stay stable.
  initial begin
    beat_t b;
    holdBeat = 1'b0; holdReq = 1'b0; enableCycles = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        holdBeat = 1'b0; holdReq = 1'b0;
      end else begin
        if (holdBeat) begin
          checks++;
          if (path_valid !== 1'b1 || path_node !== heldBeat.node || path_last !== heldBeat.last) begin
            errors++;
            $display("[TB] FAIL beatHold got v%0b n%0h l%0b expected v1 n%0h l%0b",
                     path_valid, path_node, path_last, heldBeat.node, heldBeat.last);
          end
        end
        if (holdReq) begin
          checks++;
          if (mem_read_enable !== 1'b1 || mem_addr !== heldAddr) begin
            errors++;
            $display("[TB] FAIL reqHold got en%0b a%0h expected en1 a%0h", mem_read_enable, mem_addr, heldAddr);
          end
        end
        if (path_valid === 1'b1 && path_ready) begin
          b.node = path_node; b.last = path_last;
          gotBeats.push_back(b);
        end
        holdBeat = (path_valid === 1'b1) && !path_ready;
        heldBeat.node = path_node; heldBeat.last = path_last;
        if (mem_read_enable === 1'b1) enableCycles++;
        if (mem_read_enable === 1'b1 && !wait_request) begin
          gotReads.push_back(mem_addr);
          pendAddr = mem_addr;
          respCount = memLat;
        end
        holdReq = (mem_read_enable === 1'b1) && wait_request;
        heldAddr = mem_addr;
      end
    end
  end

  // Walk the predecessor chain directly from the rules.
  task automatic modelTrace(input int src, input int dst, input int n, input logic [MAW-1:0] base);
    int cur, hops;
    int visited[$];
    beat_t b;
    expBeats.delete(); expReads.delete(); expErr = 1'b0;
    cur = dst; hops = 0;
    while (1'b1) begin
      if (cur >= n || hops > n) begin expErr = 1'b1; break; end
`ifdef PATH_TRACER_FORWARD_EN
      if (visited.size() == MAXN) begin expErr = 1'b1; break; end
`endif
      visited.push_back(cur);
      if (cur == src) break;
      expReads.push_back(MAW'(int'(base) + cur * (MDW / 8)));
      if (prevMem[cur] == NP) begin expErr = 1'b1; break; end
      cur = int'(prevMem[cur]);
      hops++;
    end
`ifdef PATH_TRACER_FORWARD_EN
    if (!expErr) begin
      for (int i = visited.size() - 1; i >= 0; i--) begin
        b.node = IW'(visited[i]); b.last = (i == 0);
        expBeats.push_back(b);
      end
    end
`else
    for (int i = 0; i < visited.size(); i++) begin
      b.node = IW'(visited[i]); b.last = !expErr && (i == visited.size() - 1);
      expBeats.push_back(b);
    end
`endif
  endtask

  task automatic loadPattern(input int p);
    for (int i = 0; i < 64; i++) prevMem[i] = NP;
    case (p)
      0: begin prevMem[1] = 8'd0; prevMem[2] = 8'd1; prevMem[3] = 8'd2; end
      1: begin prevMem[1] = 8'd2; prevMem[2] = 8'd1; end
      2: for (int i = 1; i < 20; i++) prevMem[i] = IW'(i - 1);
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input int src, input int dst, input int n, input logic [MAW-1:0] base,
                               input bit spur, output int cycles, output bit timedOut);
    gotBeats.delete(); gotReads.delete(); enableCycles = 0; curBase = base;
    @(posedge clock); #1;
    source = IW'(src); destination = IW'(dst); number_of_nodes = IW'(n);
    prev_base_address = base; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    source = IW'($urandom()); destination = IW'($urandom());
    number_of_nodes = IW'($urandom()); prev_base_address = MAW'($urandom());
    cycles = 0; timedOut = 1'b1;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clock);
      if (c == 4) start = 1'b0;
      if (spur && c == 3 && busy) start = 1'b1;
      if (done && !busy) begin cycles = c; timedOut = 1'b0; break; end
    end
    start = 1'b0;
  endtask

  task automatic runVector(input string tag, input int src, input int dst, input int n,
                           input logic [MAW-1:0] base, input bit spur, input int tErr, input int tReads);
    int cycles;
    bit timedOut;
    modelTrace(src, dst, n, base);
    applyStimulus(src, dst, n, base, spur, cycles, timedOut);
    checkOutput({tag, " timeout"}, 32'(timedOut), 32'd0);
    checkOutput({tag, " done"}, 32'(done), 32'd1);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " error"}, 32'(error), 32'(expErr));
    if (tErr >= 0) checkOutput({tag, " tableErr"}, 32'(error), 32'(tErr));
    if (tReads >= 0) checkOutput({tag, " tableReads"}, 32'(gotReads.size()), 32'(tReads));
    checkOutput({tag, " beatCount"}, 32'(gotBeats.size()), 32'(expBeats.size()));
    for (int i = 0; i < gotBeats.size() && i < expBeats.size(); i++) begin
      checkOutput($sformatf("%s beat%0d node", tag, i), 32'(gotBeats[i].node), 32'(expBeats[i].node));
      checkOutput($sformatf("%s beat%0d last", tag, i), 32'(gotBeats[i].last), 32'(expBeats[i].last));
    end
    checkOutput({tag, " readCount"}, 32'(gotReads.size()), 32'(expReads.size()));
    for (int i = 0; i < gotReads.size() && i < expReads.size(); i++)
      checkOutput($sformatf("%s read%0d addr", tag, i), 32'(gotReads[i]), 32'(expReads[i]));
    if (src == dst && src < n) begin
      checkOutput({tag, " noEnable"}, 32'(enableCycles), 32'd0);
      if (readyMode == 0) checkOutput({tag, " fastDone"}, 32'(cycles <= 3), 32'd1);
    end
    if (timedOut) begin
      reset = 1'b1;
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b0;
    end
  endtask

  initial begin
    vec_t vecs[$];
    bit timedOut;
    checks = 0; errors = 0; memLat = 2; stallMode = 0; readyMode = 0;
    curBase = '0; pendAddr = '0;
    loadPattern(0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst mem_read_enable", 32'(mem_read_enable), 32'd0);
    checkOutput("rst mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst path_valid", 32'(path_valid), 32'd0);
    checkOutput("rst path_node", 32'(path_node), 32'd0);
    checkOutput("rst path_last", 32'(path_last), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst error", 32'(error), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    //              src dst  n   base      pat stall rdy spur err      reads
    vecs.push_back('{0,  3,  5, 16'h0100,  0,  0,   0,  0,   0,       3});
    vecs.push_back('{2,  2,  5, 16'h0200,  0,  0,   0,  0,   0,       0});
    vecs.push_back('{0,  4,  5, 16'h0100,  0,  0,   0,  0,   1,       1});
    vecs.push_back('{0,  1,  3, 16'h0300,  1,  0,   0,  0,   1,       4});
    vecs.push_back('{0,  3,  5, 16'h0100,  0,  1,   1,  1,   0,       3});
    vecs.push_back('{0,  7,  5, 16'h0100,  0,  0,   0,  0,   1,       0});
    vecs.push_back('{0,  3,  5, 16'hFFF8,  0,  0,   0,  0,   0,       3});
    vecs.push_back('{0, 17, 20, 16'h0400,  2,  0,   0,  0,   LongErr, LongReads});
    vecs.push_back('{1,  3,  5, 16'h0500,  0,  2,   2,  0,   0,       2});
    foreach (vecs[i]) begin
      loadPattern(vecs[i].pattern);
      stallMode = vecs[i].stall; readyMode = vecs[i].rdy; memLat = 2;
      runVector($sformatf("vec%0d", i), vecs[i].src, vecs[i].dst, vecs[i].n, vecs[i].base,
                vecs[i].spur, vecs[i].expErr, vecs[i].expReads);
    end

    for (int r = 0; r < 25; r++) begin
      int n, src, dst;
      n = $urandom_range(1, 12);
      loadPattern(3);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 5) == 0) prevMem[i] = NP;
        else if ($urandom_range(0, 9) == 0) prevMem[i] = IW'(n);
        else prevMem[i] = IW'($urandom_range(0, n - 1));
      end
      src = $urandom_range(0, n - 1);
      dst = $urandom_range(0, n);
      stallMode = $urandom_range(0, 2); readyMode = $urandom_range(0, 2);
      memLat = $urandom_range(1, 3);
      runVector($sformatf("rnd%0d", r), src, dst, n, MAW'($urandom()), 1'b0, -1, -1);
    end

    // Reset while waiting on a read; the read data then arrives late and must be ignored.
    loadPattern(0);
    stallMode = 0; readyMode = 0; memLat = 5; curBase = 16'h0100;
    gotReads.delete();
    @(posedge clock); #1;
    source = 8'd0; destination = 8'd3; number_of_nodes = 8'd5; prev_base_address = 16'h0100; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    timedOut = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (gotReads.size() > 0) begin timedOut = 1'b0; break; end
    end
    checkOutput("abort readSeen timeout", 32'(timedOut), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      checkOutput($sformatf("abort idle%0d", c),
                  {8'd0, mem_read_enable, mem_addr, path_valid, path_last, busy, done, error},
                  32'd0);
      checkOutput($sformatf("abort node%0d", c), 32'(path_node), 32'd0);
    end
    memLat = 2;
    runVector("afterAbort", 0, 3, 5, 16'h0100, 1'b0, 0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
